// File: rtl/button_command_unit_if.sv
// Button command bundle: debouncer/sort-engine inputs and command outputs.
interface button_command_unit_if;
   logic [4:0] btn;
   logic [4:0] btnReady;
   logic       sortDone;
   logic [1:0] state;
   logic       stepPulse;
   logic       resetReq;
   logic [1:0] algoSel;
   logic [2:0] speedSel;

   modport master (
      output btn, btnReady, sortDone,
      input  state, stepPulse, resetReq, algoSel, speedSel
   );

   modport slave (
      input  btn, btnReady, sortDone,
      output state, stepPulse, resetReq, algoSel, speedSel
   );
endinterface

// File: rtl/button_command_unit.sv
// Turns debounced button presses into run/step/algo/speed commands,
// with U/D hold-to-repeat and a C long-press abort.
module button_command_unit #(
   parameter int NUM_ALGOS        = 4,
   parameter int MAX_SPEED        = 7,
   parameter int HOLD_COUNT       = 50000000,
   parameter int REPEAT_COUNT     = 10000000,
   parameter int LONG_PRESS_COUNT = 100000000
) (
   input logic                   clk,
   input logic                   rstN,
   button_command_unit_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam logic [2:0]  SPD_MAX   = 3'(MAX_SPEED);
   localparam logic [2:0]  SPD_MID   = 3'(MAX_SPEED / 2);
   localparam logic [1:0]  ALGO_LAST = 2'(NUM_ALGOS - 1);
   localparam logic [31:0] HOLD_LAST = 32'(HOLD_COUNT - 1);
   localparam logic [31:0] REP_LAST  = 32'(REPEAT_COUNT - 1);
   localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_COUNT - 1);

   state_e           state_q;
   logic             step_q, rreq_q;
   logic [1:0]       algo_q;
   logic [2:0]       speed_q;
   logic [4:0]       rdy_q, evt_q, evt_d;
   logic             cAct_q, cAct_d;
   logic [31:0]      cCnt_q, cCnt_d;
   logic [1:0]       hAct_q, hAct_d, hRep_q, hRep_d;
   logic [1:0][31:0] hCnt_q, hCnt_d;
   logic             cHeld, longHit, longFire;
   logic [1:0]       held, tick;
   logic             both, upCmd, dnCmd;

   always_comb begin
      evt_d    = rdy_q & ~bus.btnReady;
      cHeld    = bus.btn[0] & cAct_q;
      longHit  = cHeld & (cCnt_q == LONG_LAST);
      longFire = longHit & (state_q != IDLE);
      cAct_d   = evt_q[0] | (cHeld & ~longHit);
      cCnt_d   = (cAct_d && !evt_q[0]) ? cCnt_q + 32'd1 : '0;
      held     = '0;
      tick     = '0;
      hAct_d   = '0;
      hRep_d   = '0;
      hCnt_d   = '0;
      // index 0 tracks U (btn[1]), index 1 tracks D (btn[2])
      for (int b = 0; b < 2; b++) begin
         held[b]   = bus.btn[b+1] & hAct_q[b];
         tick[b]   = held[b] &
                     (hCnt_q[b] == (hRep_q[b] ? REP_LAST : HOLD_LAST));
         hAct_d[b] = evt_q[b+1] | held[b];
         hRep_d[b] = ~evt_q[b+1] & held[b] & (hRep_q[b] | tick[b]);
         hCnt_d[b] = (evt_q[b+1] || !held[b] || tick[b]) ?
                     '0 : hCnt_q[b] + 32'd1;
      end
      both  = bus.btn[1] & bus.btn[2];
      upCmd = evt_q[1] | (tick[0] & ~both);
      dnCmd = evt_q[2] | (tick[1] & ~both);
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= IDLE;
         step_q  <= 1'b0;
         rreq_q  <= 1'b0;
         algo_q  <= '0;
         speed_q <= SPD_MID;
         rdy_q   <= '1;
         evt_q   <= '0;
         cAct_q  <= 1'b0;
         cCnt_q  <= '0;
         hAct_q  <= '0;
         hRep_q  <= '0;
         hCnt_q  <= '0;
      end else begin
         rdy_q  <= bus.btnReady;
         evt_q  <= evt_d;
         cAct_q <= cAct_d;
         cCnt_q <= cCnt_d;
         hAct_q <= hAct_d;
         hRep_q <= hRep_d;
         hCnt_q <= hCnt_d;
         step_q <= 1'b0;
         rreq_q <= 1'b0;
         if (state_q == RUNNING && bus.sortDone) state_q <= DONE;
         // one command per cycle; later branches are dropped
         if (longFire) begin
            state_q <= IDLE;
            rreq_q  <= 1'b1;
         end else if (evt_q[0]) begin
            unique case (state_q)
               IDLE:    state_q <= RUNNING;
               RUNNING: state_q <= PAUSED;
               PAUSED:  state_q <= RUNNING;
               DONE: begin
                  state_q <= IDLE;
                  rreq_q  <= 1'b1;
               end
            endcase
         end else if (evt_q[4]) begin
            step_q <= (state_q == IDLE) || (state_q == PAUSED);
         end else if (evt_q[3]) begin
            if (state_q == IDLE) begin
               algo_q <= (algo_q == ALGO_LAST) ? 2'd0 : algo_q + 2'd1;
               rreq_q <= 1'b1;
            end
         end else if (upCmd) begin
            if (speed_q != SPD_MAX) speed_q <= speed_q + 3'd1;
         end else if (dnCmd) begin
            if (speed_q != 3'd0) speed_q <= speed_q - 3'd1;
         end
      end
   end

   assign bus.state     = state_q;
   assign bus.stepPulse = step_q;
   assign bus.resetReq  = rreq_q;
   assign bus.algoSel   = algo_q;
   assign bus.speedSel  = speed_q;
endmodule
